// File: rtl/usb_echo_pkg.sv
// Shared constants, FSM encoding and byte transform for the USB UART echo engine.
package usb_echo_pkg;

  localparam logic [1:0] MODE_BYTE  = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_LINE  = 2'd2;

  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StWrReq
  } state_e;

  // Lowercase ASCII folds to uppercase only in MODE_UPPER; mode 3 behaves as byte echo.
  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
    logic [7:0] r;
    r = b;
    if (m == MODE_UPPER && b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
    return r;
  endfunction

endpackage

// File: rtl/usb_uart_echo_byte_fifo.sv
// DEPTH-entry byte FIFO with combinational head and wrap-around occupancy counters.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_q, rd_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy counters define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= din;
  end

  assign level = wr_q - rd_q;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign head  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/usb_uart_echo.sv
// Buffered byte-stream echo engine driving the usb_uart strobe/wait byte interface.
module usb_uart_echo
  import usb_echo_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POLL_DIV = 2
) (
  input  logic                    clk_48mhz,
  input  logic                    resetn,
  input  logic [1:0]              mode,
  output logic                    uart_re,
  output logic                    uart_we,
  output logic [7:0]              uart_di,
  input  logic [7:0]              uart_do,
  input  logic                    uart_wait,
  output logic [7:0]              last_rx,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  state_e       state_q, state_d;
  logic         re_q, re_d, we_q, we_d;
  logic [7:0]   di_q, di_d, last_q, last_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [AW:0]  line_q, line_d;
  logic [1:0]   mode_q;

  logic         push, pop, full, empty, releasable, read_go;
  logic [7:0]   head;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk_48mhz),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (uart_do),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  always_comb begin
    releasable = !empty;
    case (mode_q)
      MODE_BYTE, MODE_UPPER: releasable = !empty;
      // A full FIFO with no CR would deadlock, so it is flushed anyway.
      MODE_LINE:             releasable = (line_q != '0) || full;
      default:               releasable = !empty;
    endcase
  end

  always_comb begin
    state_d = state_q;
    re_d    = re_q;
    we_d    = we_q;
    di_d    = di_q;
    last_d  = last_q;
    push    = 1'b0;
    pop     = 1'b0;
    read_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (releasable) begin
          pop     = 1'b1;
          we_d    = 1'b1;
          di_d    = xform(head, mode_q);
          state_d = StWrReq;
        end else if (!full && poll_q == POLL_LAST) begin
          read_go = 1'b1;
          re_d    = 1'b1;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (!uart_wait) begin
          re_d    = 1'b0;
          state_d = StRdCap;
        end
      end
      StRdCap: begin
        push    = 1'b1;
        last_d  = uart_do;
        state_d = StIdle;
      end
      StWrReq: begin
        if (!uart_wait) begin
          we_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (poll_q != POLL_LAST)                    poll_d = poll_q + PW'(1);
    else if (state_q == StIdle && !read_go)     poll_d = poll_q;
    else                                        poll_d = '0;

    line_d = line_q;
    if (push && uart_do == CHAR_CR)  line_d = line_q + 1'b1;
    else if (pop && head == CHAR_CR) line_d = line_q - 1'b1;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      state_q <= StIdle;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      di_q    <= '0;
      last_q  <= '0;
      poll_q  <= '0;
      line_q  <= '0;
      mode_q  <= mode;
    end else begin
      state_q <= state_d;
      re_q    <= re_d;
      we_q    <= we_d;
      di_q    <= di_d;
      last_q  <= last_d;
      poll_q  <= poll_d;
      line_q  <= line_d;
      if (state_q == StIdle && empty) mode_q <= mode;
    end
  end

  assign uart_re = re_q;
  assign uart_we = we_q;
  assign uart_di = di_q;
  assign last_rx = last_q;

endmodule

// File: tb/tb_usb_uart_echo.sv
// Directed bench for usb_uart_echo with a simple usb_uart device model.
module tb_usb_uart_echo;

  localparam int unsigned DEPTH = 4;

  logic       clk_48mhz = 1'b0;
  logic       resetn;
  logic [1:0] mode;
  logic       uart_re, uart_we, uart_wait;
  logic [7:0] uart_di, uart_do, last_rx;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  logic       stall = 1'b0;
  logic [7:0] src_q[$];
  logic [7:0] wr_log[$];
  int         full_re_cnt = 0;

  usb_uart_echo #(
    .DEPTH    (DEPTH),
    .POLL_DIV (2)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .resetn     (resetn),
    .mode       (mode),
    .uart_re    (uart_re),
    .uart_we    (uart_we),
    .uart_di    (uart_di),
    .uart_do    (uart_do),
    .uart_wait  (uart_wait),
    .last_rx    (last_rx),
    .fifo_level (fifo_level)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Device: stalls reads when it has nothing to give, logs accepted writes.
  initial begin
    uart_wait = 1'b0;
    uart_do   = 8'h00;
    forever begin
      @(negedge clk_48mhz);
      uart_wait = stall || (uart_re && src_q.size() == 0);
      if (uart_re && !uart_wait) uart_do = src_q.pop_front();
      if (uart_we && !uart_wait) wr_log.push_back(uart_di);
      if (uart_re && fifo_level == 3'(DEPTH)) full_re_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_48mhz);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    resetn = 1'b0;
    mode   = m;
    stall  = 1'b0;
    src_q.delete();
    wr_log.delete();
    full_re_cnt = 0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic wait_re(input int bound, output int n);
    n = 0;
    while (!uart_re && n < bound) begin tick(); n++; end
  endtask

  task automatic wait_we(input int bound, output int n);
    n = 0;
    while (!uart_we && n < bound) begin tick(); n++; end
  endtask

  task automatic wait_log(input int cnt, input int bound, output int n);
    n = 0;
    while (wr_log.size() < cnt && n < bound) begin tick(); n++; end
  endtask

  initial begin
    int n;
    logic seen;
    resetn = 1'b0;
    mode   = 2'd0;
    tick();
    tick();
    chk("rst_re", uart_re, 0);
    chk("rst_we", uart_we, 0);
    chk("rst_di", uart_di, 0);
    chk("rst_last_rx", last_rx, 0);
    chk("rst_level", fifo_level, 0);

    // Byte echo and read-to-write latency
    do_reset(2'd0);
    src_q.push_back(8'h41);
    wait_re(50, n);
    chk("byte_re_seen", uart_re, 1);
    wait_we(20, n);
    chk("byte_latency", n, 3);
    chk("byte_di", uart_di, 8'h41);
    chk("byte_last_rx", last_rx, 8'h41);
    repeat (4) tick();
    chk("byte_level", fifo_level, 0);
    chk("byte_nwr", wr_log.size(), 1);
    chk("byte_wr0", wr_log[0], 8'h41);

    // Uppercase echo
    do_reset(2'd1);
    src_q = '{8'h61, 8'h7A, 8'h7B, 8'h31};
    wait_log(4, 200, n);
    chk("up_wr0", wr_log[0], 8'h41);
    chk("up_wr1", wr_log[1], 8'h5A);
    chk("up_wr2", wr_log[2], 8'h7B);
    chk("up_wr3", wr_log[3], 8'h31);
    repeat (4) tick();
    chk("up_level", fifo_level, 0);

    // Line echo
    do_reset(2'd2);
    src_q = '{8'h68, 8'h69};
    repeat (40) tick();
    chk("line_nowr", wr_log.size(), 0);
    chk("line_level2", fifo_level, 2);
    src_q.push_back(8'h0D);
    wait_log(3, 200, n);
    repeat (4) tick();
    chk("line_wr0", wr_log[0], 8'h68);
    chk("line_wr1", wr_log[1], 8'h69);
    chk("line_wr2", wr_log[2], 8'h0D);
    chk("line_level0", fifo_level, 0);

    // Forced flush of an unterminated line when full
    do_reset(2'd2);
    src_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    wait_log(1, 200, n);
    chk("flush_first", wr_log.size(), 1);
    wait_re(50, n);
    chk("flush_read_resume", uart_re, 1);
    wait_log(4, 300, n);
    repeat (6) tick();
    chk("flush_nwr", wr_log.size(), 4);
    chk("flush_wr0", wr_log[0], 8'h31);
    chk("flush_wr1", wr_log[1], 8'h32);
    chk("flush_wr2", wr_log[2], 8'h33);
    chk("flush_wr3", wr_log[3], 8'h34);
    chk("flush_level", fifo_level, 3);
    chk("flush_no_re_full", full_re_cnt, 0);

    // Stall during a write strobe
    do_reset(2'd0);
    src_q.push_back(8'h55);
    wait_we(50, n);
    stall = 1'b1;
    chk("stall_we0", uart_we, 1);
    chk("stall_di0", uart_di, 8'h55);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (uart_we !== 1'b1 || uart_di !== 8'h55) seen = 1'b1;
    end
    chk("stall_held", seen, 0);
    stall = 1'b0;
    repeat (4) tick();
    chk("stall_we_clear", uart_we, 0);
    chk("stall_nwr", wr_log.size(), 1);
    chk("stall_wr0", wr_log[0], 8'h55);

    // Reset in the middle of a write with bytes buffered
    do_reset(2'd2);
    src_q = '{8'h41, 8'h42, 8'h43, 8'h0D};
    wait_we(200, n);
    stall = 1'b1;
    chk("mid_we", uart_we, 1);
    chk("mid_level", fifo_level, 3);
    resetn = 1'b0;
    tick();
    chk("mid_rst_re", uart_re, 0);
    chk("mid_rst_we", uart_we, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_last_rx", last_rx, 0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uart_we !== 1'b0) seen = 1'b1;
    end
    chk("mid_no_we", seen, 0);
    chk("mid_nwr", wr_log.size(), 0);
    chk("mid_level_after", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
